// File: rtl/text_term.sv
// text_term: character-terminal engine sitting between the keystroke stream
// and the VGA character renderer. Holds a COLS x ROWS ASCII screen buffer,
// a cursor and a circular top-row pointer. Scrolling moves the top pointer
// instead of copying rows.
// Optional feature macro: TEXT_TERM_CURSOR_EN (blinking '_' cursor overlay on
// the read port).
//
// Keystroke handshake: a keystroke is consumed on a rising edge where
// key_valid && key_ready are both 1. key_valid may stay high while key_ready
// is low. key_ready is registered and is high only in RUN.
module text_term #(
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int XW           = $clog2(COLS),
  parameter int YW           = $clog2(ROWS),
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  output logic          key_ready,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [7:0]    rd_ascii,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [1:0]    dbg_state
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  if (COLS < 2 || ROWS < 2 || BLINK_CYCLES < 1) begin : g_bad_params
    $error("text_term: COLS and ROWS must be >= 2 and BLINK_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] init_addr_q;
  logic [XW-1:0] clr_x_q;
  logic [XW-1:0] cur_x_q;
  logic [YW-1:0] cur_y_q;
  logic [YW-1:0] top_q;
  logic          key_ready_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem_q [CELLS];

  // Logical row y mapped through the circular top pointer (compare-and-wrap).
  function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] t,
                                             input logic [YW-1:0] y);
    logic [YW:0] sum;
    sum = {1'b0, t} + {1'b0, y};
    if (sum >= (YW+1)'(ROWS)) sum = sum - (YW+1)'(ROWS);
    return sum[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row,
                                              input logic [XW-1:0] x);
    return AW'(row) * AW'(COLS) + AW'(x);
  endfunction

  logic          accept;
  logic          is_print;
  logic          is_nl;
  logic          is_bs;
  logic          do_nl;
  logic          bs_move;
  logic [XW-1:0] bs_x;
  logic [YW-1:0] bs_y;
  logic [YW-1:0] clr_row;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;

  assign accept   = (state_q == ST_RUN) && key_valid && key_ready_q;
  assign is_print = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign is_nl    = (key_ascii == 8'h0A) || (key_ascii == 8'h0D);
  assign is_bs    = (key_ascii == 8'h08);
  // A printable in the last column wraps exactly like an explicit newline.
  assign do_nl    = accept && (is_nl || (is_print && cur_x_q == XW'(COLS - 1)));
  // The row being recycled after a scroll is the old top, one behind top_q.
  assign clr_row  = (top_q == '0) ? YW'(ROWS - 1) : top_q - 1'b1;
  assign rd_addr  = cell_addr(phys_row(top_q, rd_y), rd_x);

  // Backspace target: step left, or up to the end of the previous row.
  always_comb begin
    bs_x    = cur_x_q;
    bs_y    = cur_y_q;
    bs_move = 1'b0;
    if (cur_x_q != '0) begin
      bs_x    = cur_x_q - 1'b1;
      bs_move = 1'b1;
    end else if (cur_y_q != '0) begin
      bs_x    = XW'(COLS - 1);
      bs_y    = cur_y_q - 1'b1;
      bs_move = 1'b1;
    end
  end

  // Single buffer write port shared by INIT fill, CLEAR fill and keystrokes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 8'h20;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = init_addr_q;
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(clr_row, clr_x_q);
      end
      ST_RUN: begin
        if (accept && is_print) begin
          wr_en   = 1'b1;
          wr_addr = cell_addr(phys_row(top_q, cur_y_q), cur_x_q);
          wr_data = key_ascii;
        end else if (accept && is_bs && bs_move) begin
          wr_en   = 1'b1;
          wr_addr = cell_addr(phys_row(top_q, bs_y), bs_x);
        end
      end
      default: ;
    endcase
  end

  // Control FSM: fill, keystroke interpretation, scroll row clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      clr_x_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      top_q       <= '0;
      key_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == AW'(CELLS - 1)) begin
            init_addr_q <= '0;
            state_q     <= ST_RUN;
            key_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (do_nl) begin
            cur_x_q <= '0;
            if (cur_y_q != YW'(ROWS - 1)) begin
              cur_y_q <= cur_y_q + 1'b1;
            end else begin
              top_q       <= (top_q == YW'(ROWS - 1)) ? '0 : top_q + 1'b1;
              clr_x_q     <= '0;
              state_q     <= ST_CLEAR;
              key_ready_q <= 1'b0;
            end
          end else if (accept && is_print) begin
            cur_x_q <= cur_x_q + 1'b1;
          end else if (accept && is_bs) begin
            cur_x_q <= bs_x;
            cur_y_q <= bs_y;
          end
        end
        ST_CLEAR: begin
          clr_x_q <= clr_x_q + 1'b1;
          if (clr_x_q == XW'(COLS - 1)) begin
            state_q     <= ST_RUN;
            key_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_INIT;
          key_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage; a same-cycle read of this cell still sees the old byte.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Registered display read port.
  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= 8'h00;
    else       rd_data_q <= mem_q[rd_addr];
  end

`ifdef TEXT_TERM_CURSOR_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic          cur_hit_q;

  // Free-running blink timer: flag toggles every BLINK_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Cursor match sampled alongside the read so the overlay shares its latency.
  always_ff @(posedge clock) begin
    if (reset) cur_hit_q <= 1'b0;
    else       cur_hit_q <= (rd_x == cur_x_q) && (rd_y == cur_y_q);
  end

  assign rd_ascii = (blink_q && cur_hit_q) ? 8'h5F : rd_data_q;
`else
  assign rd_ascii = rd_data_q;
`endif

  assign key_ready = key_ready_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_text_term.sv
// Bench for text_term: directed sequence plus randomized keystrokes, checked
// against a logical-screen model where scrolling shifts whole rows.
`timescale 1ns/1ps
module tb_text_term;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int BLINK = 4;
  localparam int LIM   = 5000;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          key_valid = 1'b0;
  logic [7:0]    key_ascii = 8'h00;
  logic          key_ready;
  logic [XW-1:0] rd_x      = '0;
  logic [YW-1:0] rd_y      = '0;
  logic [7:0]    rd_ascii;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] scr [ROWS][COLS];
  int mx, my;

  // Clock and DUT
  always #5 clock = ~clock;

  text_term #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_ascii(key_ascii),
    .key_ready(key_ready), .rd_x(rd_x), .rd_y(rd_y), .rd_ascii(rd_ascii),
    .cur_x(cur_x), .cur_y(cur_y), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: logical screen, row 0 on top
  task automatic model_reset();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) scr[y][x] = 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline();
    mx = 0;
    if (my < ROWS - 1) my++;
    else begin
      for (int y = 0; y < ROWS - 1; y++)
        for (int x = 0; x < COLS; x++) scr[y][x] = scr[y+1][x];
      for (int x = 0; x < COLS; x++) scr[ROWS-1][x] = 8'h20;
    end
  endtask

  task automatic model_key(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[my][mx] = c;
      if (mx < COLS - 1) mx++;
      else model_newline();
    end else if (c == 8'h0A || c == 8'h0D) begin
      model_newline();
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my][mx] = 8'h20;
      end else if (my > 0) begin
        my--;
        mx = COLS - 1;
        scr[my][mx] = 8'h20;
      end
    end
  endtask

  // Driver: offer a key, wait (bounded) for ready, let one edge accept it.
  task automatic send(input logic [7:0] c);
    int guard;
    guard = 0;
    key_valid = 1'b1;
    key_ascii = c;
    while (!key_ready && guard < LIM) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= LIM) check("send_ready_timeout", guard, 0);
    @(negedge clock);
    key_valid = 1'b0;
    model_key(c);
  endtask

  // Number of rising edges until key_ready is seen high (bounded).
  task automatic measure_low(output int n);
    n = 0;
    while (!key_ready && n < LIM) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_cur_x"}, cur_x, mx);
    check({tag, "_cur_y"}, cur_y, my);
  endtask

  task automatic check_cells();
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        rd_x = XW'(x);
        rd_y = YW'(y);
        @(negedge clock);
`ifdef TEXT_TERM_CURSOR_EN
        if (x == mx && y == my)
          check($sformatf("cell(%0d,%0d)", x, y),
                (rd_ascii === scr[y][x]) || (rd_ascii === 8'h5F), 1);
        else
          check($sformatf("cell(%0d,%0d)", x, y), rd_ascii, scr[y][x]);
`else
        check($sformatf("cell(%0d,%0d)", x, y), rd_ascii, scr[y][x]);
`endif
      end
    end
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] c;
    logic [7:0] s [16];

    model_reset();
    // Reset with a keystroke already offered
    key_valid = 1'b1;
    key_ascii = 8'h41;
    repeat (3) @(negedge clock);
    check("rst_key_ready", key_ready, 0);
    check("rst_rd_ascii", rd_ascii, 8'h00);
    check("rst_cur_x", cur_x, 0);
    check("rst_cur_y", cur_y, 0);
    reset = 1'b0;
    measure_low(n);
    check("init_len", n, COLS * ROWS);
    @(negedge clock);
    key_valid = 1'b0;
    model_key(8'h41);
    check_cursor("first_key");
    check_cells();

    // Backspace to origin, then a no-op backspace
    send(8'h08);
    send(8'h08);
    check_cursor("bs_origin");

    // Line wrap
    repeat (COLS + 1) send(8'h61);
    check_cursor("wrap");
    check_cells();

    // Backspace across a row boundary
    send(8'h08);
    send(8'h08);
    check_cursor("bs_up");

    // Reach bottom row, then scroll twice
    while (my < ROWS - 1) send(8'h0A);
    send(8'h5A);
    send(8'h0A);
    measure_low(n);
    check("scroll1_len", n, COLS);
    check_cursor("scroll1");
    check_cells();
    send(8'h0D);
    measure_low(n);
    check("scroll2_len", n, COLS);

    // Randomized keystrokes
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 78) c = 8'h0A;
      else if (r < 81) c = 8'h0D;
      else if (r < 92) c = 8'h08;
      else if (r < 96) c = 8'($urandom_range(0, 31));
      else             c = 8'($urandom_range(127, 255));
      send(c);
    end
    check_cursor("random");
    check_cells();

    // Enough scrolls for the top pointer to wrap
    repeat (ROWS + 5) begin
      send(8'h0A);
      measure_low(n);
    end
    check_cursor("top_wrap");
    check_cells();

    // Continuous read of the cursor cell
    rd_x = XW'(mx);
    rd_y = YW'(my);
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      s[i] = rd_ascii;
    end
`ifdef TEXT_TERM_CURSOR_EN
    for (int i = 0; i < 8; i++) begin
      check($sformatf("blink_period_%0d", i), s[i+8], s[i]);
      check($sformatf("blink_toggle_%0d", i), s[i+4] !== s[i], 1);
    end
`else
    for (int i = 0; i < 16; i++)
      check($sformatf("cursor_cell_%0d", i), s[i], scr[my][mx]);
`endif

    // Reset in the middle of a scroll clear
    send(8'h0A);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midclr_key_ready", key_ready, 0);
    check("midclr_cur_x", cur_x, 0);
    check("midclr_cur_y", cur_y, 0);
    check("midclr_rd_ascii", rd_ascii, 8'h00);
    reset = 1'b0;
    model_reset();
    measure_low(n);
    check("reinit_len", n, COLS * ROWS);
    check_cells();
    send(8'h51);
    check_cursor("after_reinit");
    rd_x = '0;
    rd_y = '0;
    @(negedge clock);
    check("after_reinit_cell", rd_ascii, 8'h51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
